// File: rtl/pid_mul_sched.sv
// PID duty sequencer: time-shares one external saturating Q2.12 multiplier
// across the P, I and D terms and sums the products with saturation.
module pid_mul_sched #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         accel_vld,
  input  logic [W-1:0] xmeas,
  input  logic [W-1:0] cfg_data,
  input  logic         wrtp,
  input  logic         wrti,
  input  logic         wrtd,
  input  logic         chngxset,
  output logic         mul_start,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic         mul_done,
  input  logic [W-1:0] mul_prod,
  output logic [W-1:0] duty,
  output logic         duty_vld,
  output logic         busy,
  output logic         overrun
);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, ERR, MP, WAIT_P, MI, WAIT_I, MD, WAIT_D, SUM
  } state_t;

  function automatic logic [W-1:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? SAT_MIN : SAT_MAX;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_sat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? SAT_MIN : SAT_MAX;
    return s[W-1:0];
  endfunction

  state_t       state_q;
  logic [W-1:0] p_q, i_q, d_q, xset_q;
  logic [W-1:0] isnap_q, dsnap_q;
  logic [W-1:0] xm_q, pbuf_q;
  logic         pend_q, clr_q, ovr_q;
  logic [W-1:0] sumerr_q, preverr_q, err_q, derr_q;
  logic [W-1:0] pm_q, im_q, dm_q;
  logic [W-1:0] duty_q, ma_q, mb_q;
  logic         dvld_q, mstart_q;

  logic [W-1:0] err_d, sumerr_d, derr_d, duty_d;

  // Error terms are evaluated combinationally and only committed in ERR.
  always_comb begin
    err_d    = sub_sat(xm_q, xset_q);
    sumerr_d = add_sat(sumerr_q, err_d);
    derr_d   = sub_sat(err_d, preverr_q);
    duty_d   = add_sat(add_sat(pm_q, im_q), dm_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      i_q       <= '0;
      d_q       <= '0;
      xset_q    <= '0;
      isnap_q   <= '0;
      dsnap_q   <= '0;
      xm_q      <= '0;
      pbuf_q    <= '0;
      pend_q    <= 1'b0;
      clr_q     <= 1'b0;
      ovr_q     <= 1'b0;
      sumerr_q  <= '0;
      preverr_q <= '0;
      err_q     <= '0;
      derr_q    <= '0;
      pm_q      <= '0;
      im_q      <= '0;
      dm_q      <= '0;
      duty_q    <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      dvld_q    <= 1'b0;
      mstart_q  <= 1'b0;
    end else begin
      dvld_q   <= 1'b0;
      mstart_q <= 1'b0;

      if (wrtp) p_q <= cfg_data;
      if (wrti) i_q <= cfg_data;
      if (wrtd) d_q <= cfg_data;
      if (chngxset) begin
        xset_q <= cfg_data;
        if (state_q == IDLE) begin
          sumerr_q  <= '0;
          preverr_q <= '0;
        end else begin
          clr_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (pend_q) begin
            xm_q    <= pbuf_q;
            pend_q  <= 1'b0;
            state_q <= ERR;
          end else if (accel_vld) begin
            xm_q    <= xmeas;
            state_q <= ERR;
          end
        end
        ERR: begin
          err_q    <= err_d;
          derr_q   <= derr_d;
          sumerr_q <= sumerr_d;
          isnap_q  <= i_q;
          dsnap_q  <= d_q;
          ma_q     <= err_d;
          mb_q     <= p_q;
          mstart_q <= 1'b1;
          state_q  <= MP;
        end
        MP: state_q <= WAIT_P;
        WAIT_P: begin
          if (mul_done) begin
            pm_q     <= mul_prod;
            ma_q     <= sumerr_q;
            mb_q     <= isnap_q;
            mstart_q <= 1'b1;
            state_q  <= MI;
          end
        end
        MI: state_q <= WAIT_I;
        WAIT_I: begin
          if (mul_done) begin
            im_q     <= mul_prod;
            ma_q     <= derr_q;
            mb_q     <= dsnap_q;
            mstart_q <= 1'b1;
            state_q  <= MD;
          end
        end
        MD: state_q <= WAIT_D;
        WAIT_D: begin
          if (mul_done) begin
            dm_q    <= mul_prod;
            state_q <= SUM;
          end
        end
        SUM: begin
          duty_q <= duty_d;
          dvld_q <= 1'b1;
          // A clear requested during this computation wins over the history update.
          if (clr_q || chngxset) begin
            sumerr_q  <= '0;
            preverr_q <= '0;
            clr_q     <= 1'b0;
          end else begin
            preverr_q <= err_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Sample arriving while the FSM is occupied; IDLE consuming pend frees the slot.
      if (accel_vld) begin
        if (state_q == IDLE) begin
          if (pend_q) begin
            pbuf_q <= xmeas;
            pend_q <= 1'b1;
          end
        end else if (!pend_q) begin
          pbuf_q <= xmeas;
          pend_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign mul_start = mstart_q;
  assign mul_a     = ma_q;
  assign mul_b     = mb_q;
  assign duty      = duty_q;
  assign duty_vld  = dvld_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;

endmodule

// File: doc/pid_mul_sched.md
Name: pid_mul_sched

Overview:
- Sequencing controller for the PID duty computation. It time-shares one external saturating Q2.12 multiplier across the P, I and D terms.
- On each accelerometer sample it computes the error terms, issues three multiply requests in order, and sums the products with saturation. It then presents a duty word with a one-cycle valid.
- It sits between the config/EEPROM write strobes, the accelerometer front end and the motor duty path.

Parameters:
- W, 14, datapath and coefficient width (two's complement, saturating).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- accel_vld  in  1  one-cycle strobe; xmeas is valid this cycle.
- xmeas  in  W  measured position.
- cfg_data  in  W  config write data.
- wrtp / wrti / wrtd  in  1 each  one-cycle strobes loading the P, I and D coefficients from cfg_data.
- chngxset  in  1  one-cycle strobe loading the working setpoint from cfg_data and requesting an integrator clear.
- mul_start  out  1  one-cycle request to the shared multiplier.
- mul_a / mul_b  out  W each  multiplier operands; held stable from mul_start until mul_done.
- mul_done  in  1  one-cycle completion strobe; mul_prod is valid this cycle.
- mul_prod  in  W  saturated product.
- duty  out  W  computed duty.
- duty_vld  out  1  one-cycle strobe; duty updated this cycle.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky flag; set when a sample is dropped; cleared only by reset.

Behaviour:
- Reset values:
  - Outputs: duty=0, duty_vld=0, mul_start=0, mul_a=0, mul_b=0, busy=0, overrun=0.
  - Internal: p=i=d=0, xset=0, sumerr=0, preverr=0, pend=0, clr_req=0.
  - Reset mid-operation aborts any multiply in flight. mul_done seen in IDLE is ignored.
- Saturating arithmetic: add_sat/sub_sat clamp to 0x1FFF / 0x2000 on signed overflow; no wraparound anywhere.
- Config writes:
  - Write strobes update their registers the same cycle, in any state.
  - A computation uses the snapshot of p, i, d and xset captured in the ERR state. Writes during busy take effect from the next sample.
- Sample latching:
  - accel_vld in IDLE: latch xmeas, go to ERR next cycle.
  - accel_vld while busy with pend=0: latch xmeas into the pending buffer and set pend.
  - accel_vld while busy with pend=1: drop the sample, set overrun; the pending sample is kept.
- FSM states:
  - IDLE: if pend, consume the pending sample and go to ERR; clear pend the same cycle.
  - ERR (1 cycle): err=sub_sat(xmeas,xset); sumerr<=add_sat(sumerr,err); derr=sub_sat(err,preverr); capture coefficient snapshot. Go to MP.
  - MP: pulse mul_start with a=err, b=p. WAIT_P until mul_done; capture pm.
  - MI: pulse mul_start with a=sumerr (updated value), b=i. WAIT_I; capture im.
  - MD: pulse mul_start with a=derr, b=d. WAIT_D; capture dm.
  - SUM (1 cycle): duty<=add_sat(add_sat(pm,im),dm); duty_vld=1; preverr<=err. Go to IDLE.
- Latency: duty_vld asserts 2+3*(L+1) cycles after the ERR cycle, where L = cycles from mul_start to mul_done (L>=1).
- mul_done may arrive no earlier than the cycle after mul_start. mul_done in a non-WAIT state is ignored.
- Integrator clear (chngxset):
  - In IDLE: sumerr<=0 and preverr<=0 the same cycle. If accel_vld coincides, the clear applies first and the new xset is used.
  - While busy: set clr_req. In SUM, preverr and sumerr are forced to 0 instead of being updated (the duty from this sample is still issued). clr_req then clears.
- Simultaneous strobes:
  - Write strobes are independent and may coincide.
  - accel_vld coinciding with SUM is treated as busy (goes to the pending buffer).

Test Plan:
- Proportional only: p=0x1000, i=d=0, xset=0, xmeas=0x0100, behavioural multiplier L=14 -> duty=0x0100; duty_vld exactly 47 cycles after ERR; exactly one pulse.
- Integrator: i=0x1000, p=d=0, xmeas=0x0040 on three samples -> duty 0x0040, 0x0080, 0x00C0. Then chngxset in IDLE, next sample -> duty=0x0040.
- Derivative and saturation: d=0x1000, first sample xmeas=0x1FFF, xset=0x2000 -> err saturates to 0x1FFF; derr=0x1FFF; duty=0x1FFF (no wrap).
- Overrun: three accel_vld while busy -> the second is pending and processed after the first duty_vld; the third is dropped; overrun=1 and stays set.
- Mid-computation writes: wrtp=0x0800 during WAIT_P -> the current duty uses the old p, the next sample uses 0x0800. chngxset during WAIT_I -> sumerr=0 after SUM.
- Reset in WAIT_D: rst_n low -> all outputs 0 immediately; a late mul_done after release causes no duty_vld.
